// File: rtl/lenet_result_argmax.sv
// Snoops FC2 score writes on SRAM port F, buffers both image sets, and runs a
// sequential signed argmax per set after fc2_done, presented on valid/ready.
module lenet_result_argmax #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              fc2_done,
  input  logic              sram_write_enable_f,
  input  logic [3:0]        sram_bytemask_f,
  input  logic [1:0]        sram_waddr_f,
  input  logic [DATA_W-1:0] sram_wdata_f,
  input  logic [DATA_W-1:0] sram_wdata_f_1,
  input  logic              result_ready,
  output logic              result_valid,
  output logic [3:0]        class_idx0,
  output logic [3:0]        class_idx1,
  output logic [DATA_W-1:0] max_score0,
  output logic [DATA_W-1:0] max_score1,
  output logic              incomplete,
  output logic              lost_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;

  state_t state_q, state_d;
  logic signed [DATA_W-1:0] score0_q [NUM_CLASS];
  logic signed [DATA_W-1:0] score0_d [NUM_CLASS];
  logic signed [DATA_W-1:0] score1_q [NUM_CLASS];
  logic signed [DATA_W-1:0] score1_d [NUM_CLASS];
  logic [NUM_CLASS-1:0]     wr_map_q, wr_map_d;
  logic [4:0]               scan_idx_q, scan_idx_d;
  logic signed [DATA_W-1:0] best0_q, best0_d, best1_q, best1_d;
  logic [3:0]               best_idx0_q, best_idx0_d, best_idx1_q, best_idx1_d;
  logic                     incomplete_q, incomplete_d;
  logic                     lost_wr_q, lost_wr_d;

  logic signed [DATA_W-1:0] cur0, cur1;
  logic                     wr_evt, handshake, capture;

  assign wr_evt    = ~sram_write_enable_f;
  assign handshake = (state_q == DONE) && result_ready;

  // Scores of the class currently under scan.
  always_comb begin
    cur0 = '0;
    cur1 = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (scan_idx_q == 5'(c)) begin
        cur0 = score0_q[c];
        cur1 = score1_q[c];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    score0_d     = score0_q;
    score1_d     = score1_q;
    wr_map_d     = wr_map_q;
    scan_idx_d   = scan_idx_q;
    best0_d      = best0_q;
    best1_d      = best1_q;
    best_idx0_d  = best_idx0_q;
    best_idx1_d  = best_idx1_q;
    incomplete_d = incomplete_q;
    lost_wr_d    = lost_wr_q;
    capture      = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        capture = wr_evt;
        if (fc2_done) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end else if (wr_evt) begin
          state_d = COLLECT;
        end
      end
      SCAN: begin
        if (wr_evt) lost_wr_d = 1'b1;
        if (scan_idx_q < 5'(NUM_CLASS)) begin
          // Strict greater-than keeps the lowest index on ties.
          if (scan_idx_q == '0) begin
            best0_d     = cur0;
            best1_d     = cur1;
            best_idx0_d = '0;
            best_idx1_d = '0;
          end else begin
            if (cur0 > best0_q) begin
              best0_d     = cur0;
              best_idx0_d = scan_idx_q[3:0];
            end
            if (cur1 > best1_q) begin
              best1_d     = cur1;
              best_idx1_d = scan_idx_q[3:0];
            end
          end
          scan_idx_d = scan_idx_q + 5'd1;
        end else begin
          state_d      = DONE;
          incomplete_d = ~&wr_map_q;
        end
      end
      DONE: begin
        if (handshake) begin
          state_d   = IDLE;
          lost_wr_d = 1'b0;
          wr_map_d  = '0;
          for (int c = 0; c < NUM_CLASS; c++) begin
            score0_d[c] = '0;
            score1_d[c] = '0;
          end
        end else if (wr_evt) begin
          lost_wr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every unmasked lane of the addressed word gets the same data; lanes past NUM_CLASS drop.
    if (capture) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if ((c / 4) == int'(sram_waddr_f) && !sram_bytemask_f[3 - (c % 4)]) begin
          score0_d[c] = sram_wdata_f;
          score1_d[c] = sram_wdata_f_1;
          wr_map_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= IDLE;
      for (int c = 0; c < NUM_CLASS; c++) begin
        score0_q[c] <= '0;
        score1_q[c] <= '0;
      end
      wr_map_q     <= '0;
      scan_idx_q   <= '0;
      best0_q      <= '0;
      best1_q      <= '0;
      best_idx0_q  <= '0;
      best_idx1_q  <= '0;
      incomplete_q <= 1'b0;
      lost_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      wr_map_q     <= wr_map_d;
      scan_idx_q   <= scan_idx_d;
      best0_q      <= best0_d;
      best1_q      <= best1_d;
      best_idx0_q  <= best_idx0_d;
      best_idx1_q  <= best_idx1_d;
      incomplete_q <= incomplete_d;
      lost_wr_q    <= lost_wr_d;
    end
  end

  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == SCAN) || (state_q == DONE);
  assign class_idx0   = best_idx0_q;
  assign class_idx1   = best_idx1_q;
  assign max_score0   = best0_q;
  assign max_score1   = best1_q;
  assign incomplete   = incomplete_q;
  assign lost_wr      = lost_wr_q;

endmodule
